// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - C = A x B sequencer driving A/B read ports and C write port
module matmul_ctrl #(
    parameter int dim      = 2,
    parameter int size     = 8,
    parameter int acc_size = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_a,
    output logic [5:0]          addr_a,
    input  logic [size-1:0]     data_a,
    output logic                rd_b,
    output logic [5:0]          addr_b,
    input  logic [size-1:0]     data_b,
    output logic                wr_c,
    output logic [5:0]          addr_c,
    output logic [acc_size-1:0] data_c
);

    localparam int            CW   = (dim > 1) ? $clog2(dim) : 1;
    localparam logic [CW-1:0] LAST = CW'(dim - 1);
    localparam logic [5:0]    DIM6 = 6'(dim);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         i, j, k;
    logic [acc_size-1:0]   acc;
    logic [2*size-1:0]     prod;

    // Full-width unsigned product, then fitted to the accumulator width
    assign prod = {{size{1'b0}}, data_a} * {{size{1'b0}}, data_b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + acc_size'(prod);
                    if (k == LAST) begin
                        k     <= '0;
                        state <= WRITE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    acc <= '0;
                    if (i == LAST && j == LAST) begin
                        state <= DONE;
                    end else begin
                        state <= MAC;
                        if (j == LAST) begin
                            j <= '0;
                            i <= i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign addr_a = DIM6 * 6'(i) + 6'(k);
    assign addr_b = DIM6 * 6'(k) + 6'(j);
    assign addr_c = DIM6 * 6'(i) + 6'(j);
    assign data_c = acc;
    assign rd_a   = (state == MAC);
    assign rd_b   = (state == MAC);
    assign wr_c   = (state == WRITE);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer that computes C = A × B for square `dim`×`dim` unsigned matrices held in three instances of the team's `memory` block. It sits directly downstream of the A and B operand memories, driving their read ports, and upstream of the C result memory, driving its write port. It steps through every (i, j) result element, accumulates one product per cycle over k, and writes each finished element into C. A start/busy/done handshake brackets each multiplication.

## Interface
- `dim`, 2: matrix dimension; row-major index = `dim`*row + col; requires `dim`*`dim` ≤ 64.
- `size`, 8: operand width (A, B element width).
- `acc_size`, 17: accumulator and result width; results are taken modulo 2^`acc_size`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the last C element has been written.
- `rd_a`  out  1  read enable to memory A.
- `addr_a`  out  6  A read address.
- `data_a`  in  `size`  A read data, combinational from memory A.
- `rd_b`  out  1  read enable to memory B.
- `addr_b`  out  6  B read address.
- `data_b`  in  `size`  B read data, combinational from memory B.
- `wr_c`  out  1  write enable to memory C.
- `addr_c`  out  6  C write address.
- `data_c`  out  `acc_size`  C write data.

## Operation
- Registered state: `state`, counters `i`, `j`, `k` (each 0..`dim`-1), accumulator `acc` (`acc_size` bits).
- States:
  - IDLE: `start`=1 → MAC, with i=j=k=0 and acc=0. Otherwise stay in IDLE.
  - MAC: each edge, acc ← acc + data_a*data_b. The product is `2*size` bits, unsigned, zero-extended or truncated to `acc_size`. If k=`dim`-1, go to WRITE and set k←0; else k←k+1.
  - WRITE: each edge, acc←0. If i=j=`dim`-1, go to DONE. Else advance j; when j wraps from `dim`-1 to 0, advance i. Then go to MAC.
  - DONE: go to IDLE unconditionally.
- Combinational outputs:
  - `addr_a` = `dim`*i + k.
  - `addr_b` = `dim`*k + j.
  - `addr_c` = `dim`*i + j.
  - `data_c` = acc.
  - `rd_a` = `rd_b` = (state==MAC).
  - `wr_c` = (state==WRITE).
  - `busy` = (state!=IDLE).
  - `done` = (state==DONE).
- Arithmetic is unsigned throughout. Overflow beyond `acc_size` wraps silently, with no flag.
- `start` asserted while busy is ignored. It is not queued.
- `start` asserted in the DONE cycle is also ignored. A new run needs `start` in IDLE.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state=IDLE, i=j=k=0, acc=0.
  - Therefore `busy`=`done`=`rd_a`=`rd_b`=`wr_c`=0, all addresses 0, `data_c`=0.
- Reset mid-run aborts immediately. C elements already written keep their values. No further writes occur.
- Per element: `dim` MAC cycles plus 1 WRITE cycle.
- Start sampled at edge T:
  - MAC starts in the cycle after T.
  - The last WRITE occurs in cycle T+`dim`²(`dim`+1).
  - `done` is high for exactly one cycle: T+`dim`²(`dim`+1)+1.
  - `busy` falls with it.
  - For `dim`=2: writes in cycles T+3, T+6, T+9, T+12; `done` in cycle T+13.
- C write order: addresses 0, 1, …, `dim`²-1. Exactly one `wr_c` pulse per element.
- Memory reads are combinational. `data_a`/`data_b` must be valid in the same cycle the address is presented. No read pipeline stage.

## Test plan
- **Reset defaults:** hold `rst`=0, then release. All outputs are 0 and state is IDLE. Pulse `start` → `busy` rises next cycle.
- **Basic multiply:** A = B = [[5,3],[6,4]] (the memory reset contents). Start at edge T.
  - C writes are (addr 0, 43), (1, 27), (2, 54), (3, 34), in cycles T+3, T+6, T+9, T+12.
  - `done` is high only in cycle T+13.
- **Maximum operands:** all A, B elements = 255, `acc_size`=17. Every C element is 130050 with no wrap.
- **Truncation:** same maximum-operand stimulus with `acc_size`=16. Every C element is 130050 mod 65536 = 64514.
- **Ignored start:** pulse `start` during MAC, during WRITE and during DONE.
  - The run completes normally with exactly 4 writes and one `done`.
  - The block returns to IDLE with no second run.
- **Reset mid-run:** assert `rst` asynchronously in cycle T+7 (after the second write).
  - Outputs drop to 0 immediately with no further `wr_c`.
  - C[0]=43 and C[1]=27 are retained.
  - A new `start` recomputes all 4 elements correctly.
